// File: rtl/dmem_responder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_pkg
//  Description : Shared encodings for the MEM-stage data-memory interface:
//                access direction, access width, responder states and a
//                byte sign-extension helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_pkg;

  localparam logic [1:0] MEM_RD   = 2'b01;
  localparam logic [1:0] MEM_WR   = 2'b10;
  localparam logic       ACC_WORD = 1'b1;
  localparam logic       ACC_BYTE = 1'b0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  // Sign-extend a loaded byte to a full register width
  function automatic logic [31:0] sext8(input logic [7:0] b);
    return {{24{b[7]}}, b};
  endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_responder_array.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_array
//  Description : DEPTH_WORDS x 32 synchronous storage with per-byte write
//                enables and a registered read port. Contents are never
//                reset. Read returns the word as it was before a same-cycle
//                write.
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_array #(
  parameter int DEPTH_WORDS = 256,
  parameter int AW          = 8
) (
  input  logic          clk,
  input  logic          en,
  input  logic [3:0]    we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  // Byte-lane writes and registered read, both only when enabled
  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < 4; i++) begin
        if (we[i]) begin
          mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
      rdata <= mem[addr];
    end
  end

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_responder
//  Description : Target-side data-memory responder for the MEM stage. Takes
//                one load/store at a time, waits WAIT_STATES cycles while
//                stalling the pipeline, commits the access on the edge into
//                RESP and presents a one-cycle response. Word and byte
//                (little-endian, sign-extended loads) accesses supported.
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic [1:0]  req_rw,
  input  logic        req_word,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        stall,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int CW = (WAIT_STATES > 1) ? $clog2(WAIT_STATES + 1) : 1;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;

  logic [1:0]    lat_rw;
  logic          lat_word;
  logic          lat_err;
  logic [1:0]    lat_lane;
  logic [AW-1:0] lat_idx;
  logic [31:0]   lat_wdata;

  logic          legal, accept, req_err, commit;
  logic [1:0]    cur_rw, cur_lane;
  logic          cur_word, cur_err;
  logic [AW-1:0] cur_idx;
  logic [31:0]   cur_wdata, arr_wdata, arr_rdata;
  logic [3:0]    be;
  logic [7:0]    lane_byte;

  assign legal   = (req_rw == MEM_RD) || (req_rw == MEM_WR);
  assign accept  = (state == S_IDLE) && req_valid && legal;
  assign req_err = ((req_word == ACC_WORD) && (req_addr[1:0] != 2'b00)) ||
                   ({2'b00, req_addr[31:2]} >= 32'(DEPTH_WORDS));

  // With zero wait states the access commits on the accept edge, so the
  // storage must be driven straight from the request rather than the latch.
  assign cur_rw    = (state == S_IDLE) ? req_rw            : lat_rw;
  assign cur_word  = (state == S_IDLE) ? req_word          : lat_word;
  assign cur_err   = (state == S_IDLE) ? req_err           : lat_err;
  assign cur_lane  = (state == S_IDLE) ? req_addr[1:0]     : lat_lane;
  assign cur_idx   = (state == S_IDLE) ? req_addr[AW+1:2]  : lat_idx;
  assign cur_wdata = (state == S_IDLE) ? req_wdata         : lat_wdata;

  assign commit    = (state_nxt == S_RESP) && (state != S_RESP);
  assign arr_wdata = (cur_word == ACC_WORD) ? cur_wdata : {4{cur_wdata[7:0]}};

  // Byte enables: full word or the single addressed lane; none on error
  always_comb begin
    be = 4'b0000;
    if ((cur_rw == MEM_WR) && !cur_err) begin
      if (cur_word == ACC_WORD) be = 4'hF;
      else                      be = 4'b0001 << cur_lane;
    end
  end

  dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_array (
    .clk   (clk),
    .en    (commit),
    .we    (be),
    .addr  (cur_idx),
    .wdata (arr_wdata),
    .rdata (arr_rdata)
  );

  // State and wait counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state and wait-count logic
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      S_IDLE: begin
        if (accept) begin
          cnt_nxt   = CW'(WAIT_STATES);
          state_nxt = (WAIT_STATES > 0) ? S_WAIT : S_RESP;
        end
      end
      S_WAIT: begin
        cnt_nxt = cnt - CW'(1);
        if (cnt == CW'(1)) state_nxt = S_RESP;
      end
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Capture the accepted request; later request inputs are ignored
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_rw    <= 2'b00;
      lat_word  <= 1'b0;
      lat_err   <= 1'b0;
      lat_lane  <= 2'b00;
      lat_idx   <= '0;
      lat_wdata <= '0;
    end else if (accept) begin
      lat_rw    <= req_rw;
      lat_word  <= req_word;
      lat_err   <= req_err;
      lat_lane  <= req_addr[1:0];
      lat_idx   <= req_addr[AW+1:2];
      lat_wdata <= req_wdata;
    end
  end

  // Select the addressed byte from the registered read word
  always_comb begin
    lane_byte = arr_rdata[7:0];
    case (lat_lane)
      2'd1:    lane_byte = arr_rdata[15:8];
      2'd2:    lane_byte = arr_rdata[23:16];
      2'd3:    lane_byte = arr_rdata[31:24];
      default: lane_byte = arr_rdata[7:0];
    endcase
  end

  assign req_ready  = (state == S_IDLE);
  assign stall      = accept || (state == S_WAIT);
  assign resp_valid = (state == S_RESP);
  assign resp_err   = resp_valid && lat_err;
  assign resp_rdata = (resp_valid && (lat_rw == MEM_RD) && !lat_err) ?
                      ((lat_word == ACC_WORD) ? arr_rdata : sext8(lane_byte)) :
                      32'h0;

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dmem_responder
//  Description : Self-checking bench for dmem_responder. Two instances (two
//                and zero wait states) are driven from a byte-array reference
//                model; expected responses are queued at accept time and a
//                monitor compares them whenever resp_valid is seen.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;

  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  req_valid, req_word, req_ready, stall, resp_valid, resp_err;
  logic [1:0]  req_rw     [2];
  logic [31:0] req_addr   [2];
  logic [31:0] req_wdata  [2];
  logic [31:0] resp_rdata [2];

  int checks   = 0;
  int failures = 0;

  logic [7:0]  ref_mem [2][DEPTH*4];
  logic [32:0] exp_q0 [$];
  logic [32:0] exp_q1 [$];

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid[0]), .req_rw(req_rw[0]),
    .req_word(req_word[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .req_ready(req_ready[0]), .stall(stall[0]), .resp_valid(resp_valid[0]),
    .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0])
  );

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid[1]), .req_rw(req_rw[1]),
    .req_word(req_word[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .req_ready(req_ready[1]), .stall(stall[1]), .resp_valid(resp_valid[1]),
    .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1])
  );

  function automatic int ws(input int d);
    return (d == 0) ? 2 : 0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference: error rule, little-endian byte storage, sign-extended byte loads
  task automatic model_apply(input int d, input logic [1:0] rw, input logic word,
                             input logic [31:0] addr, input logic [31:0] wdata);
    logic        err;
    logic [31:0] rd;
    int          base, bi;
    err = (word && addr[1:0] != 2'b00) || (addr[31:2] >= 30'(DEPTH));
    rd  = 32'h0;
    if (!err) begin
      base = int'(addr[11:2]) * 4;
      bi   = int'(addr[11:0]);
      if (rw == 2'b01) begin
        if (word) rd = {ref_mem[d][base+3], ref_mem[d][base+2], ref_mem[d][base+1], ref_mem[d][base]};
        else      rd = {{24{ref_mem[d][bi][7]}}, ref_mem[d][bi]};
      end else begin
        if (word) for (int i = 0; i < 4; i++) ref_mem[d][base+i] = wdata[8*i +: 8];
        else      ref_mem[d][bi] = wdata[7:0];
      end
    end
    if (d == 0) exp_q0.push_back({err, rd});
    else        exp_q1.push_back({err, rd});
  endtask

  // Random legal-looking traffic while busy; it must have no effect
  task automatic garble(input int d);
    req_valid[d] = 1'b1;
    req_rw[d]    = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
    req_word[d]  = 1'($urandom_range(0, 1));
    req_addr[d]  = $urandom_range(0, 1023);
    req_wdata[d] = $urandom;
  endtask

  // One transaction; called at a negedge, returns at the RESP-cycle negedge
  task automatic do_req(input int d, input logic [1:0] rw, input logic word,
                        input logic [31:0] addr, input logic [31:0] wdata, input bit b2b);
    int n;
    req_valid[d] = 1'b1; req_rw[d] = rw; req_word[d] = word;
    req_addr[d]  = addr; req_wdata[d] = wdata;
    #1;
    n = 0;
    while (!req_ready[d] && n < 20) begin @(negedge clk); #1; n++; end
    if (n >= 20) begin
      chk("ready_timeout", 32'(n), 32'(0));
      req_valid[d] = 1'b0;
      return;
    end
    if (b2b) chk("b2b_accept_delay", 32'(n), 32'(1));
    chk("accept_stall", 32'(stall[d]), 32'(1));
    @(posedge clk);
    model_apply(d, rw, word, addr, wdata);
    @(negedge clk); garble(d); #1;
    n = 0;
    while (!resp_valid[d] && n < 20) begin
      chk("wait_stall", 32'(stall[d]), 32'(1));
      @(negedge clk); garble(d); #1;
      n++;
    end
    chk("latency", 32'(n), 32'(ws(d)));
    chk("resp_stall", 32'(stall[d]), 32'(0));
    chk("resp_ready", 32'(req_ready[d]), 32'(0));
    req_valid[d] = 1'b0;
  endtask

  // Scoreboard monitor: every response must match the oldest queued entry
  always @(negedge clk) begin : monitor
    logic [32:0] e;
    for (int d = 0; d < 2; d++) begin
      if (resp_valid[d]) begin
        if ((d == 0 && exp_q0.size() == 0) || (d == 1 && exp_q1.size() == 0)) begin
          checks++; failures++;
          $display("FAIL unexpected_resp dut%0d: got resp_valid=1 expected none", d);
        end else begin
          e = (d == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
          chk("resp_rdata", resp_rdata[d], e[31:0]);
          chk("resp_err", 32'(resp_err[d]), 32'(e[32]));
        end
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "simulation time limit reached");
  end

  initial begin : stim
    logic [31:0] a;
    logic        w;
    int          d, r;
    for (int i = 0; i < 2; i++) begin
      req_valid[i] = 1'b0; req_word[i] = 1'b0; req_rw[i] = 2'b00;
      req_addr[i] = 32'h0; req_wdata[i] = 32'h0;
    end
    repeat (3) @(negedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("rst_ready", 32'(req_ready[i]), 32'(1));
      chk("rst_stall", 32'(stall[i]), 32'(0));
      chk("rst_resp_valid", 32'(resp_valid[i]), 32'(0));
      chk("rst_resp_rdata", resp_rdata[i], 32'h0);
      chk("rst_resp_err", 32'(resp_err[i]), 32'(0));
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    // Give every modelled word a known value
    for (int i = 0; i < DEPTH; i++) do_req(0, 2'b10, 1'b1, 32'(i*4), $urandom, 1'b0);
    for (int i = 0; i < 16; i++)    do_req(1, 2'b10, 1'b1, 32'(i*4), $urandom, 1'b0);

    // Word store then load
    do_req(0, 2'b10, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0);
    do_req(0, 2'b01, 1'b1, 32'h10, 32'h0, 1'b0);
    // Byte lane update and sign-extended byte load
    do_req(0, 2'b10, 1'b1, 32'h10, 32'h11223344, 1'b0);
    do_req(0, 2'b10, 1'b0, 32'h13, 32'h00000080, 1'b0);
    do_req(0, 2'b01, 1'b0, 32'h13, 32'h0, 1'b0);
    do_req(0, 2'b01, 1'b1, 32'h10, 32'h0, 1'b0);
    // Errors, back to back, with no storage side effect
    do_req(0, 2'b01, 1'b1, 32'h12, 32'h0, 1'b0);
    do_req(0, 2'b01, 1'b1, 32'(DEPTH*4), 32'h0, 1'b1);
    do_req(0, 2'b10, 1'b1, 32'h12, 32'hCAFEF00D, 1'b1);
    do_req(0, 2'b10, 1'b0, 32'(DEPTH*4 + 1), 32'h000000AA, 1'b1);
    do_req(0, 2'b01, 1'b1, 32'h10, 32'h0, 1'b1);

    // Reset while a store is waiting: no response, no write
    do_req(0, 2'b10, 1'b1, 32'h20, 32'h0, 1'b0);
    @(negedge clk);
    req_valid[0] = 1'b1; req_rw[0] = 2'b10; req_word[0] = 1'b1;
    req_addr[0] = 32'h20; req_wdata[0] = 32'h5555AAAA;
    @(posedge clk);
    @(negedge clk);
    req_valid[0] = 1'b0;
    #1 chk("pre_reset_stall", 32'(stall[0]), 32'(1));
    rst_n = 1'b0;
    #1;
    chk("mid_reset_ready", 32'(req_ready[0]), 32'(1));
    chk("mid_reset_stall", 32'(stall[0]), 32'(0));
    chk("mid_reset_resp_valid", 32'(resp_valid[0]), 32'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    do_req(0, 2'b01, 1'b1, 32'h20, 32'h0, 1'b0);

    // Zero wait states
    do_req(1, 2'b10, 1'b1, 32'h8, 32'h89ABCDEF, 1'b0);
    do_req(1, 2'b01, 1'b1, 32'h8, 32'h0, 1'b0);
    do_req(1, 2'b01, 1'b0, 32'hA, 32'h0, 1'b1);

    // Requests with no access must neither stall nor respond
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      req_valid[i] = 1'b1; req_rw[i] = (i == 0) ? 2'b00 : 2'b11; req_addr[i] = 32'h4;
      for (int k = 0; k < 3; k++) begin
        #1;
        chk("noacc_stall", 32'(stall[i]), 32'(0));
        chk("noacc_ready", 32'(req_ready[i]), 32'(1));
        @(negedge clk);
      end
      req_rw[i] = (i == 0) ? 2'b11 : 2'b00;
      #1 chk("noacc_stall2", 32'(stall[i]), 32'(0));
      req_valid[i] = 1'b0;
    end

    // Random traffic against the reference model
    for (int t = 0; t < 300; t++) begin
      d = int'($urandom_range(0, 1));
      r = int'($urandom_range(0, 9));
      w = 1'($urandom_range(0, 1));
      if (r == 0) a = $urandom_range(DEPTH*4, DEPTH*4 + 4095);
      else        a = $urandom_range(0, ((d == 0) ? DEPTH : 16) * 4 - 1);
      if (w && r != 1) a[1:0] = 2'b00;
      do_req(d, ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10, w, a, $urandom, 1'b0);
    end

    repeat (5) @(negedge clk);
    chk("queue_empty", 32'(exp_q0.size() + exp_q1.size()), 32'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
